// File: rtl/sample_mac_pkg.sv
// Shared types and helpers for the sample_mac_pipe multiply-accumulate unit.
package sample_mac_pkg;

    // Widest signed value the scaling/saturation helpers operate on.
    localparam int unsigned MAX_W = 64;

    // Sideband carried alongside each product through the multiplier pipeline.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } side_t;

    // Exact product width; the unsigned operand of a mixed pair gets one extra zero bit.
    function automatic int unsigned prod_width(input int unsigned a_w, input int unsigned b_w,
                                               input bit a_signed, input bit b_signed);
        return (a_signed == b_signed) ? (a_w + b_w) : (a_w + b_w + 1);
    endfunction

    // Clip a signed value into the signed range of a width-bit word.
    function automatic logic signed [MAX_W-1:0] sat_clip(input logic signed [MAX_W-1:0] value,
                                                         input int unsigned width);
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

    // Parameter legality: at least one multiplier stage, accumulator holds a full
    // product, shift stays inside the accumulator, helpers' internal width suffices.
    function automatic bit params_legal(input int unsigned mul_stages, input int unsigned acc_w,
                                        input int unsigned p_w, input int unsigned shift,
                                        input int unsigned dout_w);
        return (mul_stages >= 1) && (acc_w >= p_w) && (shift < acc_w) &&
               (acc_w <= MAX_W) && (dout_w >= 1) && (dout_w < MAX_W);
    endfunction

endpackage

// File: rtl/sample_mac_mul_stage.sv
// Operand registers, signedness extension and MUL_STAGES-deep product pipeline.
module sample_mac_mul_stage
    import sample_mac_pkg::*;
#(
    parameter int unsigned A_W        = 6,
    parameter int unsigned B_W        = 11,
    parameter bit          A_SIGNED   = 1'b0,
    parameter bit          B_SIGNED   = 1'b1,
    parameter int unsigned MUL_STAGES = 2,
    localparam int unsigned P_W       = prod_width(A_W, B_W, A_SIGNED, B_SIGNED)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [A_W-1:0]        a,
    input  logic [B_W-1:0]        b,
    input  logic                  first,
    input  logic                  last,
    output logic signed [P_W-1:0] prod,
    output logic                  prod_valid,
    output logic                  prod_first,
    output logic                  prod_last
);

    logic [A_W-1:0]        a_q;
    logic [B_W-1:0]        b_q;
    side_t                 side_q [MUL_STAGES];
    logic                  a_fill;
    logic                  b_fill;
    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] b_ext;
    logic signed [P_W-1:0] prod_comb;

    // Operand capture and sideband shift register (first stage counts as one multiplier stage).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            b_q <= '0;
            for (int unsigned i = 0; i < MUL_STAGES; i++) begin
                side_q[i] <= '0;
            end
        end else if (ce) begin
            a_q       <= a;
            b_q       <= b;
            side_q[0] <= {in_valid, first, last};
            for (int unsigned i = 1; i < MUL_STAGES; i++) begin
                side_q[i] <= side_q[i-1];
            end
        end
    end

    // Extend both operands to the product width as signed values; product is exact in P_W bits.
    always_comb begin
        a_fill    = A_SIGNED ? a_q[A_W-1] : 1'b0;
        b_fill    = B_SIGNED ? b_q[B_W-1] : 1'b0;
        a_ext     = {{(P_W-A_W){a_fill}}, a_q};
        b_ext     = {{(P_W-B_W){b_fill}}, b_q};
        prod_comb = a_ext * b_ext;
    end

    if (MUL_STAGES == 1) begin : g_direct
        assign prod = prod_comb;
    end else begin : g_pipe
        logic signed [P_W-1:0] pipe [MUL_STAGES-1];

        // Remaining product register stages, aligned with the sideband.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int unsigned i = 0; i < MUL_STAGES - 1; i++) begin
                    pipe[i] <= '0;
                end
            end else if (ce) begin
                pipe[0] <= prod_comb;
                for (int unsigned i = 1; i < MUL_STAGES - 1; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end

        assign prod = pipe[MUL_STAGES-2];
    end

    assign prod_valid = side_q[MUL_STAGES-1].valid;
    assign prod_first = side_q[MUL_STAGES-1].first;
    assign prod_last  = side_q[MUL_STAGES-1].last;

endmodule

// File: rtl/sample_mac_pipe.sv
// Pipelined multiply-accumulate with framed accumulation, scaling and saturation.
module sample_mac_pipe
    import sample_mac_pkg::*;
#(
    parameter int unsigned A_W        = 6,
    parameter int unsigned B_W        = 11,
    parameter bit          A_SIGNED   = 1'b0,
    parameter bit          B_SIGNED   = 1'b1,
    parameter int unsigned MUL_STAGES = 2,
    parameter int unsigned ACC_W      = 24,
    parameter int unsigned SHIFT      = 0,
    parameter int unsigned DOUT_W     = 11,
    parameter bit          SAT        = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              in_valid,
    input  logic [A_W-1:0]    a,
    input  logic [B_W-1:0]    b,
    input  logic              first,
    input  logic              last,
    output logic [DOUT_W-1:0] dout,
    output logic              dout_valid,
    output logic              sat
);

    localparam int unsigned P_W      = prod_width(A_W, B_W, A_SIGNED, B_SIGNED);
    localparam bit          P_SIGNED = A_SIGNED || B_SIGNED;

    if (!params_legal(MUL_STAGES, ACC_W, P_W, SHIFT, DOUT_W)) begin : g_bad_params
        $error("sample_mac_pipe: illegal parameters (need MUL_STAGES>=1, ACC_W>=P_W, SHIFT<ACC_W)");
    end

    logic signed [P_W-1:0]    prod;
    logic                     prod_valid;
    logic                     prod_first;
    logic                     prod_last;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  acc_q;
    logic                     acc_last_q;
    logic signed [ACC_W-1:0]  scaled;
    logic signed [MAX_W-1:0]  wide;
    logic signed [MAX_W-1:0]  clipped;
    logic [DOUT_W-1:0]        dout_next;
    logic                     sat_next;

    sample_mac_mul_stage #(
        .A_W       (A_W),
        .B_W       (B_W),
        .A_SIGNED  (A_SIGNED),
        .B_SIGNED  (B_SIGNED),
        .MUL_STAGES(MUL_STAGES)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .first     (first),
        .last      (last),
        .prod      (prod),
        .prod_valid(prod_valid),
        .prod_first(prod_first),
        .prod_last (prod_last)
    );

    // Accumulate input: a closed frame (acc_last_q) behaves like first so the next sample starts at 0.
    always_comb begin
        prod_ext = P_SIGNED ? ACC_W'(prod) : ACC_W'($unsigned(prod));
        acc_base = (prod_first || acc_last_q) ? '0 : acc_q;
        acc_next = acc_base + prod_ext;
    end

    // Accumulator register; a closed frame is cleared on the next idle cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q      <= '0;
            acc_last_q <= 1'b0;
        end else if (ce) begin
            if (prod_valid) begin
                acc_q      <= acc_next;
                acc_last_q <= prod_last;
            end else begin
                if (acc_last_q) begin
                    acc_q <= '0;
                end
                acc_last_q <= 1'b0;
            end
        end
    end

    // Floor-scaling by arithmetic shift, then clip or wrap to the output width.
    always_comb begin
        scaled    = acc_q >>> SHIFT;
        wide      = MAX_W'(scaled);
        clipped   = sat_clip(wide, DOUT_W);
        dout_next = SAT ? clipped[DOUT_W-1:0] : wide[DOUT_W-1:0];
        sat_next  = SAT && (clipped != wide);
    end

    // Output register: pulse dout_valid once per closed frame, hold dout/sat otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            sat        <= 1'b0;
        end else if (ce) begin
            dout_valid <= acc_last_q;
            if (acc_last_q) begin
                dout <= dout_next;
                sat  <= sat_next;
            end
        end
    end

endmodule

// File: tb/tb_sample_mac_pipe.sv
// Scoreboard bench for sample_mac_pipe: default, wrap (SAT=0) and shifted (SHIFT=2) instances.
module tb_sample_mac_pipe;

    typedef struct {
        logic [10:0] dout;
        logic        sat;
        int unsigned cyc;
    } exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        ce    = 1'b1;
    logic [5:0]  a     = '0;
    logic [10:0] b     = '0;
    logic        first = 1'b0;
    logic        last  = 1'b0;
    logic [2:0]  iv    = '0;

    logic [10:0] d0, d1, d2;
    logic        v0, v1, v2;
    logic        s0, s1, s2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int unsigned n_cmp  = 0;
    int unsigned n_bad  = 0;
    int unsigned cyc    = 0;
    bit          ce_edge = 1'b0;

    sample_mac_pipe u_dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(iv[0]), .a(a), .b(b),
        .first(first), .last(last), .dout(d0), .dout_valid(v0), .sat(s0)
    );

    sample_mac_pipe #(.SAT(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(iv[1]), .a(a), .b(b),
        .first(first), .last(last), .dout(d1), .dout_valid(v1), .sat(s1)
    );

    sample_mac_pipe #(.SHIFT(2)) u_shift (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(iv[2]), .a(a), .b(b),
        .first(first), .last(last), .dout(d2), .dout_valid(v2), .sat(s2)
    );

    always #5 clk = ~clk;

    // ce-qualified cycle counter used to check pulse timing.
    always @(posedge clk) begin
        ce_edge = ce;
        if (ce) cyc++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic mon(input int id, input logic v, input logic [10:0] d, input logic s);
        exp_t e;
        int   sz;
        if (v !== 1'b1) return;
        case (id)
            0:       sz = q0.size();
            1:       sz = q1.size();
            default: sz = q2.size();
        endcase
        if (sz == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse[%0d]: dout_valid=1 dout=0x%0h at cycle %0d, none required",
                     id, d, cyc);
            return;
        end
        case (id)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        check($sformatf("dout[%0d]", id), 32'(d), 32'(e.dout));
        check($sformatf("sat[%0d]", id), 32'(s), 32'(e.sat));
        check($sformatf("latency[%0d]", id), cyc, e.cyc);
    endtask

    // Monitor: compare every ce-qualified output pulse against the scoreboard.
    always @(negedge clk) begin
        if (ce_edge && reset) begin
            mon(0, v0, d0, s0);
            mon(1, v1, d1, s1);
            mon(2, v2, d2, s2);
        end
    end

    task automatic send(input int id, input int av, input int bv, input bit f, input bit l,
                        input int exp_d, input bit exp_s);
        exp_t e;
        a     = 6'(av);
        b     = 11'(bv);
        first = f;
        last  = l;
        iv    = '0;
        iv[id] = 1'b1;
        if (l) begin
            e.dout = 11'(exp_d);
            e.sat  = exp_s;
            e.cyc  = cyc + 4;
            case (id)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        iv    = '0;
        first = 1'b0;
        last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout", 32'(d0), 32'h0);
        check("reset_valid", 32'(v0), 32'h0);
        check("reset_sat", 32'(s0), 32'h0);
        reset = 1'b1;
        idle(2);

        // Plain multiply mode, saturation both ways, zero operand.
        send(0, 63, -1, 1, 1, -63, 0);
        idle(6);
        send(0, 63, 1023, 1, 1, 1023, 1);
        idle(6);
        send(0, 63, -1024, 1, 1, -1024, 1);
        send(0, 0, -1024, 1, 1, 0, 0);
        idle(6);

        // Four-sample frame followed immediately by a single-sample frame.
        send(0, 10, 5, 1, 0, 0, 0);
        send(0, 10, 5, 0, 0, 0, 0);
        send(0, 10, 5, 0, 0, 0, 0);
        send(0, 10, 5, 0, 1, 200, 0);
        send(0, 2, -3, 1, 1, -6, 0);
        idle(8);

        // Same frame with a 3-cycle ce stall after sample #2; outputs must hold.
        send(0, 10, 5, 1, 0, 0, 0);
        send(0, 10, 5, 0, 0, 0, 0);
        iv = '0;
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("stall_dout", 32'(d0), 32'h7FA);
            check("stall_valid", 32'(v0), 32'h0);
            check("stall_sat", 32'(s0), 32'h0);
        end
        ce = 1'b1;
        send(0, 10, 5, 0, 0, 0, 0);
        send(0, 10, 5, 0, 1, 200, 0);
        idle(8);

        // Reset after sample #2; samples #3-#4 without first accumulate from 0.
        send(0, 10, 5, 1, 0, 0, 0);
        send(0, 10, 5, 0, 0, 0, 0);
        iv    = '0;
        reset = 1'b0;
        #2;
        check("midreset_dout", 32'(d0), 32'h0);
        check("midreset_valid", 32'(v0), 32'h0);
        check("midreset_sat", 32'(s0), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        send(0, 10, 5, 0, 0, 0, 0);
        send(0, 10, 5, 0, 1, 100, 0);
        idle(8);

        // Wrap mode and floor shift.
        send(1, 63, 1023, 1, 1, 961, 0);
        send(1, 63, -1024, 1, 1, -1024, 0);
        send(2, 10, -5, 1, 1, -13, 0);
        idle(8);

        check("drain_q0", 32'(q0.size()), 32'h0);
        check("drain_q1", 32'(q1.size()), 32'h0);
        check("drain_q2", 32'(q2.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
